rv_control_fsm: RTL
===================

Name: rv_control_fsm

Overview:
- Multi-cycle control sequencer for the lab RV32 core.
- Fetches the instruction, then uses the opcode and funct3 from the instruction decoder to classify it.
- Drives PC, instruction register, register file, writeback mux and CSR enables through IDLE→FETCH→DECODE→EXEC→WB.
- Handles jump/branch PC selection, ECALL/EBREAK halt, instruction-fetch timeout, and a retired-instruction counter.

Parameters:
- FETCH_TIMEOUT, 255: max cycles in FETCH without imem_ready before entering FAULT.
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  decoder opcode field (valid while IR is stable)
- funct3  in  3  decoder funct3 field
- br_taken  in  1  ALU branch-compare result, valid in EXEC
- imem_ready  in  1  instruction-memory data valid
- imem_req  out  1  instruction fetch request
- ir_en  out  1  load instruction register
- pc_en  out  1  update PC
- pc_sel  out  2  0=pc+4, 1=pc+imm, 2=(rs1+imm)&~1, 3=trap vector
- rf_we  out  1  register-file write enable
- wb_sel  out  2  0=ALU, 1=imm20 (LUI), 2=pc+4 (link), 3=CSR read data
- alu_src  out  1  0=rs2, 1=immediate
- csr_we  out  1  CSR write enable
- halted  out  1  sticky; ECALL/EBREAK seen
- fault  out  1  sticky; fetch timeout
- illegal  out  1  unsupported opcode (see Optional Feature)
- instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all outputs 0; instret=0; timeout counter=0.
  - Reset asserted in any state aborts the instruction immediately. No partial writeback.
- IDLE: one cycle, then FETCH.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_en=1 that same cycle, next state=DECODE, timeout counter cleared.
  - Otherwise the counter increments. When counter==FETCH_TIMEOUT-1 and imem_ready=0: next state=FAULT.
  - imem_ready in exactly the FETCH_TIMEOUT-th cycle still succeeds.
- DECODE:
  - Latch instruction class from opcode/funct3. Classes:
    - LUI 0110111
    - AUIPC 0010111
    - JAL 1101111
    - JALR 1100111
    - BRANCH 1100011
    - OPIMM 0010011
    - OP 0110011
    - CSR (1110011 with funct3≠0)
    - SYS (1110011 with funct3=0)
    - ILL (anything else)
  - SYS→HALT. ILL→TRAP if ILLEGAL_TRAP_EN, else HALT. Otherwise→EXEC.
- EXEC:
  - alu_src=1 for OPIMM, AUIPC, JALR; 0 otherwise.
  - Branch decision is sampled from br_taken here and registered.
  - Next state is always WB.
- WB (one cycle): pc_en=1, instret+=1, next state FETCH. Per class:
  - OP/OPIMM/AUIPC: rf_we=1, wb_sel=0.
  - LUI: rf_we=1, wb_sel=1.
  - JAL: rf_we=1, wb_sel=2, pc_sel=1.
  - JALR: rf_we=1, wb_sel=2, pc_sel=2.
  - BRANCH: rf_we=0; pc_sel=1 if registered taken, else 0.
  - CSR: rf_we=1, wb_sel=3, csr_we=1.
  - All others: pc_sel=0.
- Latency: 4 cycles per instruction (FETCH, DECODE, EXEC, WB) with imem_ready in the first FETCH cycle. Each stalled FETCH cycle adds one.
- Enables are single-cycle pulses. Every output not listed for a state is 0 in that state.
- HALT: absorbing until reset; halted=1; no enables; instret frozen.
- FAULT: absorbing until reset; fault=1; no enables.
- instret wraps modulo 2^INSTRET_W with no flag.

Optional Feature:
- Macro: RV_ILLEGAL_TRAP_EN.
- Defined:
  - ILL→TRAP for one cycle: pc_sel=3, pc_en=1, illegal=1 (pulse), instret unchanged, then FETCH.
- Undefined:
  - ILL→HALT, halted=1, illegal=1 sticky until reset.
  - TRAP state and pc_sel=3 are never produced.

Decomposition:
- Shared package rv_pkg holds:
  - opcode localparams (OPC_LUI … OPC_SYSTEM);
  - pc_sel_e and wb_sel_e enums;
  - instr_class_e;
  - state_e (IDLE, FETCH, DECODE, EXEC, WB, TRAP, HALT, FAULT).
- One natural sub-module: rv_instr_classify, a combinational function from opcode/funct3 to instr_class_e. It is reused by the bench scoreboard.
- The FSM and counters stay in rv_control_fsm.

Test Plan:
- Reset release, ADDI (0x00500093), imem_ready immediate → ir_en at cycle 2; rf_we=1, wb_sel=0, pc_sel=0 at cycle 5; instret=1.
- BEQ with br_taken=1, then BEQ with br_taken=0 → WB pc_sel=1 then 0; rf_we=0 both; instret=2.
- JAL then JALR → WB wb_sel=2 with pc_sel=1, then wb_sel=2 with pc_sel=2; LUI → wb_sel=1; CSRRW (funct3=001) → csr_we=1, wb_sel=3.
- imem_ready held low with FETCH_TIMEOUT=8 → fault=1 after 8 FETCH cycles; no pc_en ever; stays until reset.
- ECALL (0x00000073) → halted=1 after DECODE; no further imem_req. Opcode 0000011 → with macro: pc_sel=3 pulse, then FETCH; without macro: halted=1 and illegal=1.
- reset asserted mid-EXEC → all outputs 0 asynchronously; instret=0; restart via IDLE→FETCH.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types for the RV32 multi-cycle control sequencer: opcodes, mux selects,
// instruction classes and sequencer states.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_JALR  = 2'd2,
    PC_TRAP  = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU   = 2'd0,
    WB_IMM20 = 2'd1,
    WB_LINK  = 2'd2,
    WB_CSR   = 2'd3
  } wb_sel_e;

  typedef enum logic [3:0] {
    CL_LUI,
    CL_AUIPC,
    CL_JAL,
    CL_JALR,
    CL_BRANCH,
    CL_OPIMM,
    CL_OP,
    CL_CSR,
    CL_SYS,
    CL_ILL
  } instr_class_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    TRAP,
    HALT,
    FAULT
  } state_e;

endpackage

// File: rtl/rv_instr_classify.sv
// Combinational opcode/funct3 to instruction-class map; SYSTEM splits into
// CSR accesses (funct3 != 0) and ECALL/EBREAK (funct3 == 0).
module rv_instr_classify
  import rv_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  output instr_class_e iclass
);

  always_comb begin
    iclass = CL_ILL;
    unique case (opcode)
      OPC_LUI:    iclass = CL_LUI;
      OPC_AUIPC:  iclass = CL_AUIPC;
      OPC_JAL:    iclass = CL_JAL;
      OPC_JALR:   iclass = CL_JALR;
      OPC_BRANCH: iclass = CL_BRANCH;
      OPC_OPIMM:  iclass = CL_OPIMM;
      OPC_OP:     iclass = CL_OP;
      OPC_SYSTEM: iclass = (funct3 == 3'b000) ? CL_SYS : CL_CSR;
      default:    iclass = CL_ILL;
    endcase
  end

endmodule

// File: rtl/rv_control_fsm.sv
// Multi-cycle control sequencer (IDLE->FETCH->DECODE->EXEC->WB) for the lab RV32 core.
// Build option RV_ILLEGAL_TRAP_EN: unsupported opcodes trap (pc_sel=3) instead of halting.
//
// state  | meaning
// IDLE   | one cycle after reset
// FETCH  | imem_req high, wait for imem_ready (bounded by FETCH_TIMEOUT)
// DECODE | classify opcode/funct3, latch class
// EXEC   | drive alu_src, register br_taken
// WB     | writeback, PC update, retire
// TRAP   | one-cycle jump to trap vector on illegal opcode
// HALT   | ECALL/EBREAK (or illegal without trap), absorbing
// FAULT  | fetch timeout, absorbing
module rv_control_fsm
  import rv_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 255,
  parameter int unsigned INSTRET_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 br_taken,
  input  logic                 imem_ready,
  output logic                 imem_req,
  output logic                 ir_en,
  output logic                 pc_en,
  output logic [1:0]           pc_sel,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 alu_src,
  output logic                 csr_we,
  output logic                 halted,
  output logic                 fault,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  localparam int unsigned     TO_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  state_e          state, state_n;
  instr_class_e    cls, cls_q;
  logic            br_q;
  logic [TO_W-1:0] to_cnt;
  pc_sel_e         pc_sel_n;
  wb_sel_e         wb_sel_n;

  rv_instr_classify u_classify (
    .opcode (opcode),
    .funct3 (funct3),
    .iclass (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cls_q   <= CL_OP;
      br_q    <= 1'b0;
      to_cnt  <= '0;
      instret <= '0;
    end else begin
      state <= state_n;
      // Stall count only grows while we stay in FETCH; any exit clears it.
      if (state == FETCH && state_n == FETCH) to_cnt <= to_cnt + TO_W'(1);
      else                                    to_cnt <= '0;
      if (state == DECODE) cls_q <= cls;
      if (state == EXEC)   br_q  <= br_taken;
      if (state == WB)     instret <= instret + INSTRET_W'(1);
    end
  end

  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pc_sel_n = PC_PLUS4;
    rf_we    = 1'b0;
    wb_sel_n = WB_ALU;
    alu_src  = 1'b0;
    csr_we   = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    illegal  = 1'b0;

    unique case (state)
      IDLE: state_n = FETCH;

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en   = 1'b1;
          state_n = DECODE;
        end else if (to_cnt == TO_LAST) begin
          state_n = FAULT;
        end
      end

      DECODE: begin
        unique case (cls)
          CL_SYS: state_n = HALT;
`ifdef RV_ILLEGAL_TRAP_EN
          CL_ILL: state_n = TRAP;
`else
          CL_ILL: state_n = HALT;
`endif
          default: state_n = EXEC;
        endcase
      end

      EXEC: begin
        alu_src = (cls_q == CL_OPIMM) || (cls_q == CL_AUIPC) || (cls_q == CL_JALR);
        state_n = WB;
      end

      WB: begin
        pc_en   = 1'b1;
        state_n = FETCH;
        unique case (cls_q)
          CL_OP, CL_OPIMM, CL_AUIPC: rf_we = 1'b1;
          CL_LUI: begin
            rf_we    = 1'b1;
            wb_sel_n = WB_IMM20;
          end
          CL_JAL: begin
            rf_we    = 1'b1;
            wb_sel_n = WB_LINK;
            pc_sel_n = PC_IMM;
          end
          CL_JALR: begin
            rf_we    = 1'b1;
            wb_sel_n = WB_LINK;
            pc_sel_n = PC_JALR;
          end
          CL_BRANCH: pc_sel_n = br_q ? PC_IMM : PC_PLUS4;
          CL_CSR: begin
            rf_we    = 1'b1;
            wb_sel_n = WB_CSR;
            csr_we   = 1'b1;
          end
          default: pc_sel_n = PC_PLUS4;
        endcase
      end

      TRAP: begin
`ifdef RV_ILLEGAL_TRAP_EN
        pc_en    = 1'b1;
        pc_sel_n = PC_TRAP;
        illegal  = 1'b1;
`endif
        state_n = FETCH;
      end

      HALT: begin
        halted = 1'b1;
`ifndef RV_ILLEGAL_TRAP_EN
        illegal = (cls_q == CL_ILL);
`endif
      end

      FAULT: fault = 1'b1;
    endcase
  end

  assign pc_sel = pc_sel_n;
  assign wb_sel = wb_sel_n;

endmodule
